dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Two-requester arbiter in front of the data-memory/IO decoder. It shares the single data-bus port (write enable, byte address, write data, read data) between the single-cycle MIPS core and a debug/loader requester.
- The CPU has default priority. The debug port is served in CPU-idle cycles, or by force after a bounded wait, which stalls the core for a short burst.
- Sits between mips/top-level glue and dMemoryDecoder.

Parameters:
- ADDR_W, 8, bus address width (decoder consumes addr[7:0]).
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive blocked debug cycles before a forced grant (>=1).
- DBG_BURST, 2, maximum beats the debug port keeps the bus in a forced grant (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU performs a load/store this cycle.
- cpu_we  in  1  CPU store (memwrite).
- cpu_addr  in  ADDR_W  CPU address (aluout slice).
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  read data to CPU.
- cpu_stall  out  1  hold PC / suppress register writeback.
- dbg_req  in  1  debug access request; held until dbg_ack.
- dbg_we  in  1  debug write.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_rdata  out  DATA_W  read data to debug port.
- dbg_ack  out  1  debug beat completes this cycle.
- bus_we  out  1  to decoder writeEN.
- bus_addr  out  ADDR_W  to decoder addr.
- bus_wdata  out  DATA_W  to decoder writeData.
- bus_rdata  in  DATA_W  from decoder readData (combinational read).

Behaviour:
- FSM states: CPU_OWN, DBG_OWN. Reset -> CPU_OWN, wait_cnt=0, burst_cnt=0.
- Reset values: cpu_stall=0, dbg_ack=0, bus_we=0. bus_addr and bus_wdata follow the CPU mux.
- cpu_rdata and dbg_rdata are both a combinational copy of bus_rdata. Each is valid only in its owner's granted cycle.
- **CPU_OWN, cpu_req=1:**
  - bus driven from cpu_* combinationally; bus_we=cpu_we; dbg_ack=0.
  - If dbg_req=1, wait_cnt++ (saturating at MAX_WAIT).
- **CPU_OWN, cpu_req=0, dbg_req=1:**
  - bus driven from dbg_*; bus_we=dbg_we; dbg_ack=1 (same cycle, zero added latency).
  - wait_cnt cleared.
- **CPU_OWN, neither request:** bus from cpu_*, bus_we=0, wait_cnt cleared.
- **Forced grant:** if dbg_req=1 and cpu_req=1 and wait_cnt==MAX_WAIT-1 at the clock edge, next state = DBG_OWN, burst_cnt=0, wait_cnt cleared. With MAX_WAIT=4 the debug port is blocked exactly 4 cycles.
- **DBG_OWN:**
  - cpu_stall=1 (registered state decode, glitch-free). cpu_req is ignored and the CPU re-presents the same access after the stall.
  - bus from dbg_*; bus_we=dbg_we&dbg_req; dbg_ack=dbg_req.
  - burst_cnt++ per acked beat.
  - Exit to CPU_OWN when burst_cnt==DBG_BURST-1 with ack, or when dbg_req=0. A dropped request costs one idle stalled cycle with bus_we=0.
- A write completes in its ack/grant cycle (decoder writes on that rising edge). A read returns in the same cycle.
- Simultaneous cpu_req and dbg_req in CPU_OWN below threshold: the CPU wins.
- dbg_req deasserted while waiting: wait_cnt cleared, no grant.
- Asynchronous reset mid-DBG_OWN: FSM returns to CPU_OWN immediately and all outputs take reset values. A partially issued burst is abandoned; the debug master must re-request.
- bus_we is never asserted for a requester without its grant. Write enables are never ORed across requesters.

Decomposition:
- Package dbus_pkg:
  - typedef enum logic {CPU_OWN, DBG_OWN} arb_state_t.
  - typedef struct {we, addr, wdata} bus_req_t.
  - localparams for default MAX_WAIT/DBG_BURST.
- One natural sub-module: dbus_mux, the combinational 2:1 bus_req_t select and write-enable gating, driven by grant_dbg.
- FSM and counters stay in dbus_arbiter.

Test Plan:
- Reset, then cpu_req=1, cpu_we=1, addr=0x80, wdata=0x1234 -> bus_we=1, bus_addr=0x80, cpu_stall=0; after reset_n low mid-cycle, bus_we=0 immediately.
- cpu_req=0, dbg_req=1, dbg_we=0, addr=0x84, bus_rdata=0xABCD -> dbg_ack=1 same cycle, dbg_rdata=0xABCD, no stall.
- cpu_req=1 every cycle, dbg_req=1 from cycle 0 -> 4 cycles with dbg_ack=0, then cpu_stall=1 and dbg_ack=1 for exactly 2 cycles (DBG_BURST=2), then cpu_stall=0.
- Forced grant, dbg_req dropped after the first beat -> 1 ack, 1 stalled idle cycle (bus_we=0), return to CPU_OWN; total stall = 2 cycles.
- dbg_req pulses for 3 cycles while cpu busy, then drops -> no grant, wait_cnt resets; a new request waits the full 4 cycles again.
- Async reset asserted during DBG_OWN -> cpu_stall=0, dbg_ack=0 without a clock edge; state CPU_OWN after release.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared types and defaults for the data-bus arbiter.
package dbus_pkg;

    localparam int unsigned BUS_ADDR_W    = 8;
    localparam int unsigned BUS_DATA_W    = 32;
    localparam int unsigned DEF_MAX_WAIT  = 4;
    localparam int unsigned DEF_DBG_BURST = 2;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DBG_OWN = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/dbus_mux.sv
// Combinational 2:1 bus request select with write-enable gating.
module dbus_mux
    import dbus_pkg::*;
(
    input  bus_req_t cpu,
    input  bus_req_t dbg,
    input  logic     grant_dbg,
    input  logic     we_en,
    output bus_req_t bus
);

    bus_req_t sel;

    // Only the granted requester's write enable can reach the bus.
    always_comb begin
        sel    = grant_dbg ? dbg : cpu;
        bus    = sel;
        bus.we = we_en & sel.we;
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares the data-memory bus between the CPU (default owner) and a debug port
// that is served in idle cycles or forcibly after a bounded wait.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int unsigned ADDR_W    = BUS_ADDR_W,
    parameter int unsigned DATA_W    = BUS_DATA_W,
    parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
    parameter int unsigned DBG_BURST = DEF_DBG_BURST
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int unsigned BURST_W = $clog2(DBG_BURST + 1);

    arb_state_t         state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [BURST_W-1:0] burst_cnt, burst_nxt;
    logic               grant_dbg, we_en, ack;
    bus_req_t           cpu_bus, dbg_bus, sel_bus;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CPU_OWN;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        burst_nxt = burst_cnt;
        grant_dbg = 1'b0;
        we_en     = 1'b0;
        ack       = 1'b0;
        case (state)
            CPU_OWN: begin
                wait_nxt = '0;
                if (cpu_req) begin
                    we_en = 1'b1;
                    if (dbg_req) begin
                        // Debug has been blocked long enough: steal the bus next cycle.
                        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                            state_nxt = DBG_OWN;
                            burst_nxt = '0;
                        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                            wait_nxt = wait_cnt + WAIT_W'(1);
                        end else begin
                            wait_nxt = wait_cnt;
                        end
                    end
                end else if (dbg_req) begin
                    grant_dbg = 1'b1;
                    we_en     = 1'b1;
                    ack       = 1'b1;
                end
            end
            DBG_OWN: begin
                grant_dbg = 1'b1;
                we_en     = dbg_req;
                ack       = dbg_req;
                if (dbg_req) begin
                    burst_nxt = burst_cnt + BURST_W'(1);
                end
                if (!dbg_req || burst_cnt == BURST_W'(DBG_BURST - 1)) begin
                    state_nxt = CPU_OWN;
                end
            end
            default: state_nxt = CPU_OWN;
        endcase
    end

    assign cpu_bus = '{we: cpu_we, addr: BUS_ADDR_W'(cpu_addr), wdata: BUS_DATA_W'(cpu_wdata)};
    assign dbg_bus = '{we: dbg_we, addr: BUS_ADDR_W'(dbg_addr), wdata: BUS_DATA_W'(dbg_wdata)};

    // Reset forces the CPU path with writes and acks suppressed, without waiting for a clock.
    dbus_mux u_mux (
        .cpu       (cpu_bus),
        .dbg       (dbg_bus),
        .grant_dbg (grant_dbg & reset_n),
        .we_en     (we_en & reset_n),
        .bus       (sel_bus)
    );

    assign bus_we    = sel_bus.we;
    assign bus_addr  = ADDR_W'(sel_bus.addr);
    assign bus_wdata = DATA_W'(sel_bus.wdata);
    assign dbg_ack   = ack & reset_n;
    assign cpu_stall = (state == DBG_OWN);
    assign cpu_rdata = bus_rdata;
    assign dbg_rdata = bus_rdata;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: directed scenarios then randomized traffic.
module tb_dbus_arbiter;

    localparam int unsigned MAX_WAIT  = 4;
    localparam int unsigned DBG_BURST = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;

    dbus_arbiter #(
        .ADDR_W(8), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .DBG_BURST(DBG_BURST)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ack;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    // Reference model: who owns the bus, how many cycles debug has been refused,
    // and how many beats it has had during a forced grant.
    bit m_dbg_owner = 1'b0;
    int m_blocked   = 0;
    int m_beats     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic rst, input logic creq, input logic cwe,
                        input logic [7:0] caddr, input logic [31:0] cwd,
                        input logic dreq, input logic dwe,
                        input logic [7:0] daddr, input logic [31:0] dwd,
                        input logic [31:0] rd);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = !rst;
        cpu_req   = creq;  cpu_we = cwe;  cpu_addr = caddr;  cpu_wdata = cwd;
        dbg_req   = dreq;  dbg_we = dwe;  dbg_addr = daddr;  dbg_wdata = dwd;
        bus_rdata = rd;
        e.rdata = rd;  e.stall = 1'b0;  e.ack = 1'b0;  e.we = 1'b0;
        e.addr  = caddr;  e.wdata = cwd;
        if (rst) begin
            m_dbg_owner = 1'b0;  m_blocked = 0;  m_beats = 0;
        end else if (!m_dbg_owner) begin
            if (creq) begin
                e.we = cwe;
                if (dreq) begin
                    m_blocked++;
                    if (m_blocked == MAX_WAIT) begin
                        m_dbg_owner = 1'b1;  m_blocked = 0;  m_beats = 0;
                    end
                end else begin
                    m_blocked = 0;
                end
            end else begin
                m_blocked = 0;
                if (dreq) begin
                    e.ack = 1'b1;  e.we = dwe;  e.addr = daddr;  e.wdata = dwd;
                end
            end
        end else begin
            e.stall = 1'b1;  e.addr = daddr;  e.wdata = dwd;
            e.ack = dreq;  e.we = dwe & dreq;
            if (dreq) begin
                m_beats++;
                if (m_beats == DBG_BURST) m_dbg_owner = 1'b0;
            end else begin
                m_dbg_owner = 1'b0;
            end
        end
        exp_q.push_back(e);
    endtask

    // CPU busy every cycle and debug holding its request, with fixed data.
    task automatic contend(input int n, input logic dwe);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, 1'b0, 8'h10 + 8'(i), 32'hC000_0000 + 32'(i),
                 1'b1, dwe, 8'h40 + 8'(i), 32'hD000_0000 + 32'(i), 32'h5555_0000 + 32'(i));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("cpu_stall", 32'(cpu_stall), 32'(mon_e.stall));
                check("dbg_ack",   32'(dbg_ack),   32'(mon_e.ack));
                check("bus_we",    32'(bus_we),    32'(mon_e.we));
                check("bus_addr",  32'(bus_addr),  32'(mon_e.addr));
                check("bus_wdata", bus_wdata,      mon_e.wdata);
                check("cpu_rdata", cpu_rdata,      mon_e.rdata);
                check("dbg_rdata", dbg_rdata,      mon_e.rdata);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog at %0t: got no finish expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic creq, dreq;
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 8'h22, 32'h77, 1'b1, 1'b1, 8'h33, 32'h88, 32'h1);
        // CPU store, then reset asserted between edges with the store still presented.
        step(1'b0, 1'b1, 1'b1, 8'h80, 32'h1234, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 8'h80, 32'h1234, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        idle(1);
        // Debug read in a CPU-idle cycle.
        step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h84, 32'h0, 32'hABCD);
        idle(1);
        // Forced grant: 4 blocked, 2 stalled beats, then blocked again.
        contend(8, 1'b1);
        idle(1);
        // Forced grant with the request dropped after the first beat.
        contend(5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h90, 32'h9, 1'b0, 1'b1, 8'h91, 32'h19, 32'h0);
        step(1'b0, 1'b1, 1'b0, 8'h92, 32'hA, 1'b0, 1'b0, 8'h93, 32'h1A, 32'h0);
        // Three blocked cycles, drop, then a fresh request must wait the full count.
        contend(3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hA0, 32'h1, 1'b0, 1'b0, 8'hA1, 32'h2, 32'h3);
        contend(6, 1'b0);
        idle(1);
        // Reset in the middle of a forced burst.
        contend(5, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'hB0, 32'hB0, 1'b1, 1'b1, 8'hB1, 32'hB1, 32'hB2);
        step(1'b0, 1'b1, 1'b0, 8'hB4, 32'hB4, 1'b1, 1'b1, 8'hB5, 32'hB5, 32'hB6);
        idle(1);
        // Randomized traffic: CPU mostly busy, debug request changes occasionally.
        dreq = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            creq = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 4) == 0) dreq = ~dreq;
            step(($urandom_range(0, 299) == 0), creq, 1'($urandom), 8'($urandom), $urandom,
                 dreq, 1'($urandom), 8'($urandom), $urandom, $urandom);
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
